// File: rtl/msk_round_sequencer.sv
// msk_round_sequencer
//   Control FSM for an iterative masked datapath: an MSKregEn state register,
//   a masked round function of fixed LATENCY and an MSKmux picking either the
//   fresh input shares or the round-function output. Only public control is
//   driven here; the shares never pass through this block.
//
//   Parameters
//     NROUNDS  rounds per job (>=1)
//     LATENCY  cycles from state-register output to valid round output (>=1)
//
//   Ports
//     clk_i          clock, all state on the rising edge
//     rst_ni         asynchronous active-low reset
//     in_valid_i     input shares valid at the datapath input
//     in_ready_o     job accepted on in_valid_i & in_ready_o
//     out_valid_o    state register holds the final result
//     out_ready_i    result consumed on out_valid_o & out_ready_i
//     rnd_valid_i    fresh randomness available      (MSKSEQ_RND_HS_EN only)
//     rnd_ready_o    randomness consumed this cycle   (MSKSEQ_RND_HS_EN only)
//     st_en_o        state-register enable (combinational)
//     st_load_o      mux select, 1 = input shares, 0 = round output
//     round_o        current round index, 0..NROUNDS-1 (registered)
//     last_round_o   round_o == NROUNDS-1 while in START/WAIT
//
//   Build option
//     MSKSEQ_RND_HS_EN  when defined, adds the randomness handshake and START
//                       stalls until rnd_valid_i. When undefined, randomness is
//                       treated as always available and START lasts one cycle.
//
//   state | meaning
//   IDLE  | waiting for a job, in_ready_o=1
//   START | round launched, waiting for randomness
//   WAIT  | round function in flight, lat_cnt counting down
//   DONE  | result held in state register until consumed
module msk_round_sequencer #(
    parameter int NROUNDS = 10,
    parameter int LATENCY = 2,
    localparam int RW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
`ifdef MSKSEQ_RND_HS_EN
    input  logic          rnd_valid_i,
    output logic          rnd_ready_o,
`endif
    output logic          st_en_o,
    output logic          st_load_o,
    output logic [RW-1:0] round_o,
    output logic          last_round_o
);

    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [RW-1:0] ROUND_LAST = RW'(NROUNDS - 1);
    localparam logic [LW-1:0] LAT_INIT   = LW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic          rnd_ok;

`ifdef MSKSEQ_RND_HS_EN
    assign rnd_ok      = rnd_valid_i;
    assign rnd_ready_o = (state_q == START);
`else
    assign rnd_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            round_q   <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        lat_cnt_d   = lat_cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        st_en_o     = 1'b0;
        st_load_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    st_en_o   = 1'b1;
                    st_load_o = 1'b1;
                    round_d   = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (rnd_ok) begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else begin
                    st_en_o = 1'b1;
                    if (round_q == ROUND_LAST) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = START;
                    end
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        // Result is sampled by the consumer before this edge,
                        // so the next job can overwrite the state register now.
                        st_en_o   = 1'b1;
                        st_load_o = 1'b1;
                        round_d   = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign round_o      = round_q;
    assign last_round_o = ((state_q == START) || (state_q == WAIT)) && (round_q == ROUND_LAST);

endmodule

// File: tb/tb_msk_round_sequencer.sv
module tb_msk_round_sequencer;

    localparam int N   = 3;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       st_en, st_load, last_round;
    logic [1:0] round;
    logic       rnd_valid, rnd_ready;

    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic       st_en2, st_load2, last_round2;
    logic [0:0] round2;
    logic       rnd_valid2, rnd_ready2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msk_round_sequencer #(.NROUNDS(N), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
`ifdef MSKSEQ_RND_HS_EN
        .rnd_valid_i(rnd_valid), .rnd_ready_o(rnd_ready),
`endif
        .st_en_o(st_en), .st_load_o(st_load),
        .round_o(round), .last_round_o(last_round)
    );

    msk_round_sequencer #(.NROUNDS(1), .LATENCY(1)) dut_min (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
`ifdef MSKSEQ_RND_HS_EN
        .rnd_valid_i(rnd_valid2), .rnd_ready_o(rnd_ready2),
`endif
        .st_en_o(st_en2), .st_load_o(st_load2),
        .round_o(round2), .last_round_o(last_round2)
    );

`ifndef MSKSEQ_RND_HS_EN
    assign rnd_ready  = 1'b0;
    assign rnd_ready2 = 1'b0;
`endif

    // ---------------- toy masked datapath driven by the sequencer ------------
    logic [7:0]  din0, din1;
    logic [15:0] sreg;
    logic [15:0] dl0, dl1;

    function automatic logic [7:0] rotl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rc(input int r);
        return 8'(8'h11 * (r + 1));
    endfunction

    function automatic logic [15:0] rf(input logic [15:0] s, input logic [1:0] r);
        return {rotl(s[15:8]) ^ rc(int'(r)), rotl(s[7:0])};
    endfunction

    function automatic logic [7:0] gold(input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int r = 0; r < N; r++) v = rotl(v) ^ rc(r);
        return v;
    endfunction

    always @(posedge clk) begin
        dl0 <= rf(sreg, round);
        dl1 <= dl0;
        if (st_en) sreg <= st_load ? {din0, din1} : dl1;
    end

    // ---------------- scoreboard --------------------------------------------
    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    typedef struct {
        logic       st_en;
        logic       st_load;
        logic [1:0] round;
        logic       last_round;
        logic       out_valid;
        logic       in_ready;
    } ctl_t;

    exp_t exp_q[$];
    ctl_t ctl_q[$];
    bit   seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ctl_q.size() > 0) begin
                ctl_t c;
                c = ctl_q.pop_front();
                chk("trace_st_en", 32'(st_en), 32'(c.st_en));
                chk("trace_st_load", 32'(st_load), 32'(c.st_load));
                chk("trace_round", 32'(round), 32'(c.round));
                chk("trace_last_round", 32'(last_round), 32'(c.last_round));
                chk("trace_out_valid", 32'(out_valid), 32'(c.out_valid));
                chk("trace_in_ready", 32'(in_ready), 32'(c.in_ready));
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_valid_cycle", 32'(cyc), 32'(e.cycle));
                    chk("result_data", 32'(sreg[15:8] ^ sreg[7:0]), 32'(e.data));
                end
            end
            if (out_valid && out_ready) seen = 1'b0;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] x, input logic [7:0] m);
        din0 = x ^ m;
        din1 = m;
        in_valid = 1'b1;
    endtask

    initial begin
        int t0;
        int bad;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rnd_valid = 1'b1;
        din0 = '0; din1 = '0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_st_en", 32'(st_en), 32'd0);
        chk("rst_st_load", 32'(st_load), 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_last_round", 32'(last_round), 32'd0);
        chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_round", 32'(round), 32'd0);

        // Job A: full control trace; in_valid held high past IDLE is ignored.
        t0 = cyc;
        load(8'hA5, 8'h3C);
        for (int k = 0; k <= 10; k++) begin
            ctl_t c;
            c.st_en      = (k == 0) || (k == 3) || (k == 6) || (k == 9);
            c.st_load    = (k == 0);
            c.round      = (k <= 3) ? 2'd0 : (k <= 6) ? 2'd1 : 2'd2;
            c.last_round = (k >= 7) && (k <= 9);
            c.out_valid  = (k == 10);
            c.in_ready   = (k == 0) || (k == 10);
            ctl_q.push_back(c);
        end
        exp_q.push_back('{gold(8'hA5), t0 + 10});
        tick(1);
        din0 = 8'hFF; din1 = 8'h00;
        tick(5);
        in_valid = 1'b0;
        tick(6);

        // Job B with backpressure, then Job C back-to-back from DONE.
        t0 = cyc;
        out_ready = 1'b0;
        load(8'h5A, 8'hC3);
        exp_q.push_back('{gold(8'h5A), t0 + 10});
        tick(1);
        in_valid = 1'b0;
        tick(9);
        din0 = 8'h00; din1 = 8'h77;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_st_en", 32'(st_en), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick(1);
        end
        t0 = cyc;
        out_ready = 1'b1;
        load(8'h81, 8'h6E);
        #1;
        chk("b2b_st_en", 32'(st_en), 32'd1);
        chk("b2b_st_load", 32'(st_load), 32'd1);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back('{gold(8'h81), t0 + 10});
        tick(1);
        in_valid = 1'b0;
        tick(11);

`ifdef MSKSEQ_RND_HS_EN
        // Job D: randomness withheld for 4 cycles in round 1 START.
        t0 = cyc;
        load(8'h13, 8'h9B);
        exp_q.push_back('{gold(8'h13), t0 + 14});
        tick(1);
        in_valid = 1'b0;
        tick(3);
        rnd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_rnd_ready", 32'(rnd_ready), 32'd1);
            chk("stall_st_en", 32'(st_en), 32'd0);
            chk("stall_round", 32'(round), 32'd1);
            tick(1);
        end
        rnd_valid = 1'b1;
        tick(12);
`endif

        // Job E aborted by reset while in WAIT.
        load(8'h42, 8'h24);
        tick(1);
        in_valid = 1'b0;
        tick(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_st_en", 32'(st_en), 32'd0);
        chk("abort_round", 32'(round), 32'd0);
        chk("abort_last_round", 32'(last_round), 32'd0);
        tick(2);
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (st_en || out_valid) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        tick(1);

        // Job F after abort.
        t0 = cyc;
        load(8'hE7, 8'h55);
        exp_q.push_back('{gold(8'hE7), t0 + 10});
        tick(1);
        in_valid = 1'b0;
        tick(12);

        chk("pending_results", 32'(exp_q.size()), 32'd0);
        chk("pending_trace", 32'(ctl_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // NROUNDS=1, LATENCY=1 instance: out_valid 3 cycles after accept.
    initial begin
        int t;
        in_valid2 = 1'b0; out_ready2 = 1'b1; rnd_valid2 = 1'b1;
        @(posedge rst_n);
        tick(2);
        t = cyc;
        in_valid2 = 1'b1;
        #1;
        chk("min_accept_st_en", 32'(st_en2), 32'd1);
        tick(1);
        in_valid2 = 1'b0;
        tick(1);
        chk("min_wait_st_en", 32'(st_en2), 32'd1);
        chk("min_wait_last_round", 32'(last_round2), 32'd1);
        chk("min_early_out_valid", 32'(out_valid2), 32'd0);
        tick(1);
        chk("min_out_cycle", 32'(cyc - t), 32'd3);
        chk("min_out_valid", 32'(out_valid2), 32'd1);
        tick(1);
        chk("min_out_drop", 32'(out_valid2), 32'd0);
    end

endmodule
